// File: rtl/pwm_decode_multi.sv
// Multi-lane PDM/PWM density decoder: counts ones per lrclk half-frame per lane,
// saturates, and presents left/right samples with valid strobes and overflow flags.
module pwm_decode_multi #(
    parameter int LANES       = 1,
    parameter int CNT_W       = 8,
    parameter int INT_FRAME   = 0,
    parameter int HALF_PERIOD = 256
) (
    input  logic                   mclk,
    input  logic                   reset_n,
    input  logic [LANES-1:0]       data,
    input  logic                   lrclk,
    output logic                   lrclk_out,
    output logic [LANES*CNT_W-1:0] l,
    output logic [LANES*CNT_W-1:0] r,
    output logic                   l_valid,
    output logic                   r_valid,
    output logic [LANES-1:0]       l_ovf,
    output logic [LANES-1:0]       r_ovf,
    output logic                   lrsel
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic ph;
    logic ph_d;
    logic rise;
    logic fall;
    logic primed_l;
    logic primed_r;

    logic [CNT_W-1:0] lcnt [LANES];
    logic [CNT_W-1:0] rcnt [LANES];
    logic [LANES-1:0] lovf;
    logic [LANES-1:0] rovf;

    generate
        if (INT_FRAME == 0) begin : g_ext
            logic sync1;

            always_ff @(posedge mclk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1 <= 1'b0;
                    ph    <= 1'b0;
                end else begin
                    sync1 <= lrclk;
                    ph    <= sync1;
                end
            end
        end else begin : g_int
            localparam int DIV_W = $clog2(HALF_PERIOD);
            localparam logic [DIV_W-1:0] RELOAD = DIV_W'(HALF_PERIOD - 1);

            logic [DIV_W-1:0] div;
            logic             unused_lrclk;

            assign unused_lrclk = lrclk;

            // Reload on zero makes every half-frame exactly HALF_PERIOD cycles long.
            always_ff @(posedge mclk or negedge reset_n) begin
                if (!reset_n) begin
                    div <= '0;
                    ph  <= 1'b0;
                end else if (div == '0) begin
                    div <= RELOAD;
                    ph  <= ~ph;
                end else begin
                    div <= div - 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            ph_d <= 1'b0;
        end else begin
            ph_d <= ph;
        end
    end

    assign rise      = ph & ~ph_d;
    assign fall      = ~ph & ph_d;
    assign lrclk_out = ph;
    assign lrsel     = 1'b0;

    // The edge-cycle bit seeds the opposite counter, so it lands in the new window.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            l     <= '0;
            r     <= '0;
            l_ovf <= '0;
            r_ovf <= '0;
            lovf  <= '0;
            rovf  <= '0;
            for (int i = 0; i < LANES; i++) begin
                lcnt[i] <= '0;
                rcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (rise) begin
                    l[i*CNT_W +: CNT_W] <= lcnt[i];
                    l_ovf[i]            <= lovf[i];
                    lcnt[i]             <= '0;
                    lovf[i]             <= 1'b0;
                    rcnt[i]             <= {{(CNT_W-1){1'b0}}, data[i]};
                end else if (fall) begin
                    r[i*CNT_W +: CNT_W] <= rcnt[i];
                    r_ovf[i]            <= rovf[i];
                    rcnt[i]             <= '0;
                    rovf[i]             <= 1'b0;
                    lcnt[i]             <= {{(CNT_W-1){1'b0}}, data[i]};
                end else if (!ph) begin
                    if (data[i]) begin
                        if (lcnt[i] == CNT_MAX) lovf[i] <= 1'b1;
                        else                    lcnt[i] <= lcnt[i] + 1'b1;
                    end
                end else begin
                    if (data[i]) begin
                        if (rcnt[i] == CNT_MAX) rovf[i] <= 1'b1;
                        else                    rcnt[i] <= rcnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // The first window after reset is partial, so its capture is not announced.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            l_valid  <= 1'b0;
            r_valid  <= 1'b0;
            primed_l <= 1'b0;
            primed_r <= 1'b0;
        end else begin
            l_valid <= rise & primed_l;
            r_valid <= fall & primed_r;
            if (rise) primed_l <= 1'b1;
            if (fall) primed_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_decode_multi.sv
// Directed bench for pwm_decode_multi: three instances (2-lane 8-bit external frame,
// 1-lane 4-bit external frame, 1-lane internal frame) driven from shared stimulus.
module tb_pwm_decode_multi;

    logic       mclk;
    logic       reset_n;
    logic       lrclk;
    logic [1:0] data;

    logic        lrclk_out_a, l_valid_a, r_valid_a, lrsel_a;
    logic [15:0] l_a, r_a;
    logic [1:0]  l_ovf_a, r_ovf_a;

    logic       lrclk_out_b, l_valid_b, r_valid_b, lrsel_b;
    logic [3:0] l_b, r_b;
    logic       l_ovf_b, r_ovf_b;

    logic       lrclk_out_c, l_valid_c, r_valid_c, lrsel_c;
    logic [7:0] l_c, r_c;
    logic       l_ovf_c, r_ovf_c;

    int vec = 0;
    int err = 0;

    logic h1, h2, h3, alt;
    int   pc;

    int          la_n, ra_n, dbl_a;
    logic [15:0] la_last, ra_last;
    logic [1:0]  la_ovf, ra_ovf;
    logic        prev_lva, prev_rva;
    int          lb_n, rb_n;
    logic [3:0]  lb_last, rb_last;
    logic        lb_ovf, rb_ovf;
    int          lc_n, rc_n, c_last_tog, c_min_iv, c_max_iv;
    logic [7:0]  lc_last, rc_last;
    logic        lc_ovf, rc_ovf, c_prev;

    pwm_decode_multi #(.LANES(2), .CNT_W(8), .INT_FRAME(0), .HALF_PERIOD(256)) dut_a (
        .mclk(mclk), .reset_n(reset_n), .data(data), .lrclk(lrclk),
        .lrclk_out(lrclk_out_a), .l(l_a), .r(r_a), .l_valid(l_valid_a), .r_valid(r_valid_a),
        .l_ovf(l_ovf_a), .r_ovf(r_ovf_a), .lrsel(lrsel_a)
    );

    pwm_decode_multi #(.LANES(1), .CNT_W(4), .INT_FRAME(0), .HALF_PERIOD(256)) dut_b (
        .mclk(mclk), .reset_n(reset_n), .data(data[0]), .lrclk(lrclk),
        .lrclk_out(lrclk_out_b), .l(l_b), .r(r_b), .l_valid(l_valid_b), .r_valid(r_valid_b),
        .l_ovf(l_ovf_b), .r_ovf(r_ovf_b), .lrsel(lrsel_b)
    );

    pwm_decode_multi #(.LANES(1), .CNT_W(8), .INT_FRAME(1), .HALF_PERIOD(16)) dut_c (
        .mclk(mclk), .reset_n(reset_n), .data(data[0]), .lrclk(lrclk),
        .lrclk_out(lrclk_out_c), .l(l_c), .r(r_c), .l_valid(l_valid_c), .r_valid(r_valid_c),
        .l_ovf(l_ovf_c), .r_ovf(r_ovf_c), .lrsel(lrsel_c)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic assert_reset();
        @(negedge mclk);
        reset_n = 1'b0;
        lrclk   = 1'b0;
        data    = 2'b00;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0; alt = 1'b0;
        pc = 0;
        repeat (2) @(negedge mclk);
    endtask

    task automatic release_reset();
        @(negedge mclk);
        reset_n = 1'b1;
    endtask

    // mode 0: all ones, 1: lane0 = ~ph model / lane1 alternating, 2: ones only on ph edges, 3: zeros.
    // h2/h3 model the two-flop synchroniser plus ph_d, i.e. ph and ph_d as seen by the DUT.
    task automatic run(input int cycles, input int half, input int mode);
        la_n = 0; ra_n = 0; dbl_a = 0; prev_lva = 1'b0; prev_rva = 1'b0;
        la_last = '0; ra_last = '0; la_ovf = '0; ra_ovf = '0;
        lb_n = 0; rb_n = 0; lb_last = '0; rb_last = '0; lb_ovf = 1'b0; rb_ovf = 1'b0;
        lc_n = 0; rc_n = 0; lc_last = '0; rc_last = '0; lc_ovf = 1'b0; rc_ovf = 1'b0;
        c_prev = lrclk_out_c; c_last_tog = -1; c_min_iv = 1000; c_max_iv = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge mclk);
            if (l_valid_a) begin la_n++; la_last = l_a; la_ovf = l_ovf_a; if (prev_lva) dbl_a++; end
            if (r_valid_a) begin ra_n++; ra_last = r_a; ra_ovf = r_ovf_a; if (prev_rva) dbl_a++; end
            prev_lva = l_valid_a;
            prev_rva = r_valid_a;
            if (l_valid_b) begin lb_n++; lb_last = l_b; lb_ovf = l_ovf_b; end
            if (r_valid_b) begin rb_n++; rb_last = r_b; rb_ovf = r_ovf_b; end
            if (l_valid_c) begin lc_n++; lc_last = l_c; lc_ovf = l_ovf_c; end
            if (r_valid_c) begin rc_n++; rc_last = r_c; rc_ovf = r_ovf_c; end
            if (lrclk_out_c !== c_prev) begin
                if (c_last_tog >= 0) begin
                    if (k - c_last_tog < c_min_iv) c_min_iv = k - c_last_tog;
                    if (k - c_last_tog > c_max_iv) c_max_iv = k - c_last_tog;
                end
                c_last_tog = k;
                c_prev = lrclk_out_c;
            end
            h3 = h2; h2 = h1; h1 = lrclk;
            pc++;
            if (pc == half) begin
                lrclk = ~lrclk;
                pc = 0;
            end
            alt = ~alt;
            case (mode)
                0:       data = 2'b11;
                1:       data = {alt, ~h2};
                2:       data = {2{h2 ^ h3}};
                default: data = 2'b00;
            endcase
        end
    endtask

    task automatic test_reset();
        assert_reset();
        vec++;
        if ({l_a, r_a} !== 32'h0) begin err++; $display("[TB] FAIL reset_a_samples: got %h expected 0", {l_a, r_a}); end
        vec++;
        if ({l_valid_a, r_valid_a, l_ovf_a, r_ovf_a, lrclk_out_a, lrsel_a} !== 8'h0) begin
            err++; $display("[TB] FAIL reset_a_flags: got %b expected 0", {l_valid_a, r_valid_a, l_ovf_a, r_ovf_a, lrclk_out_a, lrsel_a});
        end
        vec++;
        if ({l_b, r_b, l_valid_b, r_valid_b, l_ovf_b, r_ovf_b, lrclk_out_b} !== 13'h0) begin
            err++; $display("[TB] FAIL reset_b: got %h expected 0", {l_b, r_b, l_valid_b, r_valid_b, l_ovf_b, r_ovf_b, lrclk_out_b});
        end
        vec++;
        if ({l_c, r_c, l_valid_c, r_valid_c, l_ovf_c, r_ovf_c, lrclk_out_c} !== 21'h0) begin
            err++; $display("[TB] FAIL reset_c: got %h expected 0", {l_c, r_c, l_valid_c, r_valid_c, l_ovf_c, r_ovf_c, lrclk_out_c});
        end
        release_reset();
    endtask

    task automatic test_full_density();
        assert_reset();
        release_reset();
        run(700, 100, 0);
        vec++;
        if (la_n != 2) begin err++; $display("[TB] FAIL t1_l_pulses: got %0d expected 2", la_n); end
        vec++;
        if (ra_n != 2) begin err++; $display("[TB] FAIL t1_r_pulses: got %0d expected 2", ra_n); end
        vec++;
        if (dbl_a != 0) begin err++; $display("[TB] FAIL t1_pulse_width: got %0d long pulses expected 0", dbl_a); end
        vec++;
        if (la_last !== 16'h6464) begin err++; $display("[TB] FAIL t1_l: got %h expected 6464", la_last); end
        vec++;
        if (ra_last !== 16'h6464) begin err++; $display("[TB] FAIL t1_r: got %h expected 6464", ra_last); end
        vec++;
        if ({la_ovf, ra_ovf} !== 4'b0) begin err++; $display("[TB] FAIL t1_ovf: got %b expected 0", {la_ovf, ra_ovf}); end
    endtask

    task automatic test_lane_patterns();
        assert_reset();
        release_reset();
        run(700, 100, 1);
        vec++;
        if (la_last !== {8'd50, 8'd100}) begin err++; $display("[TB] FAIL t2_l: got %h expected %h", la_last, {8'd50, 8'd100}); end
        vec++;
        if (ra_last !== {8'd50, 8'd0}) begin err++; $display("[TB] FAIL t2_r: got %h expected %h", ra_last, {8'd50, 8'd0}); end
    endtask

    task automatic test_overflow();
        assert_reset();
        release_reset();
        run(200, 40, 0);
        vec++;
        if (lb_n != 1 || rb_n != 1) begin err++; $display("[TB] FAIL t3_pulses: got l=%0d r=%0d expected 1 1", lb_n, rb_n); end
        vec++;
        if ({lb_last, lb_ovf} !== {4'd15, 1'b1}) begin err++; $display("[TB] FAIL t3_l_sat: got %0d ovf=%b expected 15 ovf=1", lb_last, lb_ovf); end
        vec++;
        if ({rb_last, rb_ovf} !== {4'd15, 1'b1}) begin err++; $display("[TB] FAIL t3_r_sat: got %0d ovf=%b expected 15 ovf=1", rb_last, rb_ovf); end
        run(200, 40, 3);
        vec++;
        if ({lb_last, lb_ovf} !== {4'd0, 1'b0}) begin err++; $display("[TB] FAIL t3_l_zero: got %0d ovf=%b expected 0 ovf=0", lb_last, lb_ovf); end
        vec++;
        if ({rb_last, rb_ovf} !== {4'd0, 1'b0}) begin err++; $display("[TB] FAIL t3_r_zero: got %0d ovf=%b expected 0 ovf=0", rb_last, rb_ovf); end
    endtask

    task automatic test_internal_frame();
        assert_reset();
        release_reset();
        run(200, 100, 0);
        vec++;
        if (c_min_iv != 16 || c_max_iv != 16) begin
            err++; $display("[TB] FAIL t4_period: got min=%0d max=%0d expected 16", c_min_iv, c_max_iv);
        end
        vec++;
        if (lc_n < 4 || rc_n < 4) begin err++; $display("[TB] FAIL t4_pulses: got l=%0d r=%0d expected >=4", lc_n, rc_n); end
        vec++;
        if (lc_last !== 8'd16 || lc_ovf !== 1'b0) begin err++; $display("[TB] FAIL t4_l: got %0d ovf=%b expected 16 ovf=0", lc_last, lc_ovf); end
        vec++;
        if (rc_last !== 8'd16 || rc_ovf !== 1'b0) begin err++; $display("[TB] FAIL t4_r: got %0d ovf=%b expected 16 ovf=0", rc_last, rc_ovf); end
    endtask

    task automatic test_mid_reset();
        assert_reset();
        release_reset();
        run(350, 100, 0);
        @(negedge mclk);
        reset_n = 1'b0;
        #1;
        vec++;
        if ({l_a, r_a, l_valid_a, r_valid_a, l_ovf_a, r_ovf_a, lrclk_out_a} !== 39'h0) begin
            err++; $display("[TB] FAIL t5_async_clear: got %h expected 0", {l_a, r_a, l_valid_a, r_valid_a, l_ovf_a, r_ovf_a, lrclk_out_a});
        end
        assert_reset();
        release_reset();
        run(700, 100, 0);
        vec++;
        if (la_n != 2 || ra_n != 2) begin err++; $display("[TB] FAIL t5_reprime: got l=%0d r=%0d expected 2 2", la_n, ra_n); end
        vec++;
        if (la_last !== 16'h6464 || ra_last !== 16'h6464) begin
            err++; $display("[TB] FAIL t5_values: got l=%h r=%h expected 6464 6464", la_last, ra_last);
        end
    endtask

    task automatic test_edge_cycle();
        assert_reset();
        release_reset();
        run(200, 10, 2);
        vec++;
        if (la_n < 5 || ra_n < 5) begin err++; $display("[TB] FAIL t6_pulses: got l=%0d r=%0d expected >=5", la_n, ra_n); end
        vec++;
        if (la_last !== 16'h0101) begin err++; $display("[TB] FAIL t6_l: got %h expected 0101", la_last); end
        vec++;
        if (ra_last !== 16'h0101) begin err++; $display("[TB] FAIL t6_r: got %h expected 0101", ra_last); end
    endtask

    initial begin
        reset_n = 1'b0;
        lrclk   = 1'b0;
        data    = 2'b00;
        test_reset();
        test_full_density();
        test_lane_patterns();
        test_overflow();
        test_internal_frame();
        test_mid_reset();
        test_edge_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/pwm_decode_multi.md
Name: pwm_decode_multi

Overview:
Parametrised multi-lane successor to the single-lane PDM/PWM density decoder, fully synchronous to mclk. Each lane carries a 1-bit density stream time-multiplexed left/right by lrclk. The block counts ones per half-frame, saturates, and presents per-lane L/R samples with valid strobes and overflow flags. Frame timing comes either from an external lrclk, synchronised internally, or from an internal divider. Sits between the board audio/PWM input pins and the audio mixer.

Parameters:
LANES, 1, number of independent data lanes (1..8)
CNT_W, 8, counter and sample width in bits (4..16)
INT_FRAME, 0, 0 = frame from lrclk input; 1 = frame generated internally
HALF_PERIOD, 256, mclk cycles per half-frame when INT_FRAME=1 (>=2)

Ports:
mclk  in  1  sole clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
data  in  LANES  density bit streams, sampled on mclk
lrclk  in  1  external frame clock, async to mclk; ignored when INT_FRAME=1
lrclk_out  out  1  frame phase in use: synchronised lrclk, or generated phase
l  out  LANES*CNT_W  left samples, lane i at bits [i*CNT_W +: CNT_W]
r  out  LANES*CNT_W  right samples, same packing as l
l_valid  out  1  one-cycle strobe, l updated
r_valid  out  1  one-cycle strobe, r updated
l_ovf  out  LANES  per-lane saturation flag for the current l sample
r_ovf  out  LANES  per-lane saturation flag for the current r sample
lrsel  out  1  microphone L/R select, tied 0

Behaviour:
- Reset, async on reset_n low: l, r, l_ovf, r_ovf, all counters, and sync and divider state go to 0. l_valid, r_valid, and lrclk_out also go to 0. primed_l and primed_r clear.
- External frame (INT_FRAME=0): lrclk passes through a 2-flop synchroniser to give ph. A third flop holds ph_d. rise = ph & ~ph_d; fall = ~ph & ph_d. lrclk_out = ph.
- Internal frame (INT_FRAME=1): a down-counter reloads HALF_PERIOD-1 and toggles ph at 0. A half-frame is therefore exactly HALF_PERIOD cycles. rise and fall are derived identically from ph and ph_d.
- Left window = ph low; right window = ph high.
- Each cycle, per lane: while ph=0, lcnt += data[i]; while ph=1, rcnt += data[i].
- Saturation: a counter at 2^CNT_W-1 holds its value and sets its lane's sticky ovf bit. No wrap-around.
- On a rise cycle:
  - l[i] <= lcnt[i]; l_ovf[i] <= lovf_sticky[i].
  - lcnt and lovf_sticky clear.
  - rcnt[i] <= data[i]. The edge-cycle bit starts the new window, so no bit is lost or double-counted.
  - l_valid pulses for 1 cycle, provided primed_l is set. primed_l then sets.
- On a fall cycle: mirror the rise case with r, rcnt, r_valid, primed_r; lcnt[i] <= data[i].
- Latency: the sample is registered on the edge-detect cycle. Valid is asserted the same cycle l/r change. In external mode that is 3 mclk after the lrclk transition.
- Priming: the first window after reset is partial, so its capture updates l/r but does not pulse valid. Valid first pulses on the second rise (l) or fall (r) after reset.
- rise and fall are mutually exclusive by construction. A phase shorter than 2 mclk may be missed by the synchroniser; this is unsupported and needs no detection.
- l/r hold their value between strobes. Downstream may sample them on valid only.
- Reset asserted mid-window discards all partial counts. Priming restarts.

Test Plan:
1. LANES=1, CNT_W=8, external lrclk with 100 mclk per half, data constantly 1 -> from the second frame, l=r=100 with l_valid/r_valid single-cycle pulses; no pulse on the first rise after reset.
2. LANES=2, lane0 data=1 only during ph low, lane1 data alternating 1/0 -> l[7:0]=100, r[7:0]=0, l[15:8]=50, r[15:8]=50 (±1 from phase alignment).
3. CNT_W=4, half-frame 40 cycles, data=1 -> l=r=15, l_ovf=r_ovf=1. Then switch data to 0 -> next samples are 0 with ovf=0.
4. INT_FRAME=1, HALF_PERIOD=16, data=1 -> lrclk_out toggles every 16 mclk; each steady-state sample =16; count exact with no lost edge-cycle bit.
5. Pulse reset_n low mid-window, then release -> all outputs 0; first post-reset capture raises no valid; second capture is correct.
6. Check edge-cycle accounting: lrclk phase = 10 mclk, data=1 only on the synchronised edge cycle -> the bit appears in the new window's sample (value 1), never the old.
